fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer between the program-counter datapath and the instruction-memory bus.
//  Owns the fetch-address register and issues one outstanding imem request at a time.
//  Buffers the returned word for decode with a valid/ready handshake.
//  Applies redirects from branch/jump/JR/COP0 resolution, drops stale responses and flags bus timeouts.
// PARAMETERS
//  RESET_ADDR   32'h80000200  fetch address loaded by reset
//  TIMEOUT_CYC  255           max cycles in WAIT without imem_rvalid; 0 disables timeout
// PORTS
//  clk             in   1   sole clock, rising edge
//  rest_n          in   1   asynchronous active-low reset
//  redirect_valid  in   1   1-cycle pulse: restart fetch at redirect_addr
//  redirect_addr   in   32  new fetch target (branch/jump/JR/COP0)
//  imem_req        out  1   fetch request
//  imem_addr       out  32  fetch address; stable while imem_req && !imem_gnt
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   read data valid (exactly one per grant)
//  imem_rdata      in   32  instruction word
//  inst_valid      out  1   inst/inst_pc/inst_rt_addr valid for decode
//  inst_ready      in   1   decode consumes when inst_valid && inst_ready
//  inst            out  32  instruction word
//  inst_pc         out  32  address of inst
//  inst_rt_addr    out  32  inst_pc + 4 (link address)
//  fetch_err       out  1   1-cycle pulse: timeout or misaligned redirect
//  err_addr        out  32  faulting address, valid with fetch_err, held until next error
// BEHAVIOUR
//  Reset (async assert): state=IDLE, fetch_pc=RESET_ADDR, kill=0, timer=0; all outputs 0.
//  States:
//  - IDLE: entered on reset; always goes to REQ next cycle.
//  - REQ: imem_req=1, imem_addr=fetch_pc.
//    On imem_gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32), go to WAIT.
//  - WAIT: imem_req=0; timer increments each cycle.
//    On imem_rvalid with kill=0: latch inst, inst_pc=req_pc, inst_rt_addr=req_pc+4, go to RESP.
//    On imem_rvalid with kill=1: discard data, clear kill, go to REQ.
//  - RESP: inst_valid=1, outputs held stable. On inst_ready: inst_valid<=0, go to REQ.
//  - ERR: imem_req=0, inst_valid=0. Any imem_rvalid is ignored. Leave only on a valid redirect.
//  Latency:
//  - reset release -> imem_req: 1 cycle.
//  - gnt and rvalid in the same cycle as their request are not legal; rvalid comes >=1 cycle after gnt.
//  - rvalid -> inst_valid: 1 cycle.
//  - inst_ready -> next imem_req: 1 cycle.
//  Redirect (highest priority; fetch_pc<=redirect_addr in every state):
//  - REQ, no gnt: request stays up with the old address until gnt; kill<=1; then WAIT.
//  - REQ with gnt in the same cycle: go to WAIT, kill<=1, fetch_pc=redirect_addr (no +4).
//  - WAIT, no rvalid: kill<=1, stay in WAIT, timer unaffected.
//  - WAIT with rvalid in the same cycle: response dropped, kill<=0, go to REQ.
//  - RESP: inst_valid<=0, go to REQ. If inst_ready is asserted in the same cycle, the handshake
//    counts as complete; flushing decode is the producer's job.
//  - ERR or IDLE: go to REQ.
//  - redirect_addr[1:0]!=0: fetch_err pulse, err_addr=redirect_addr, go to ERR, kill<=(WAIT or granted).
//  Timeout:
//  - timer clears on entry to WAIT and holds at 0 outside WAIT.
//  - When timer==TIMEOUT_CYC-1 and no rvalid: fetch_err pulse, err_addr=req_pc, go to ERR.
//  - A redirect in the same cycle wins: no error is raised.
//  - Timer width is $clog2(TIMEOUT_CYC+1). TIMEOUT_CYC=0 means the timer never fires.
//  Reset mid-operation: immediate return to reset values. An in-flight rvalid after reset release
//  while in IDLE/REQ is ignored.
// STRUCTURE
//  common.v: `FETCH_ST_IDLE/REQ/WAIT/RESP/ERR state encodings (3-bit), `FETCH_RESET_ADDR default.
//  Sub-module fetch_timer: clear/enable/limit counter, outputs expire pulse.
//  Everything else is inline: FSM, fetch_pc, req_pc, kill flag, output register.
// TESTING
//  1. Release reset, gnt next cycle, rvalid 2 cycles later with 32'h24080001, inst_ready=1
//     -> imem_addr=80000200; inst_pc=80000200, inst_rt_addr=80000204; next imem_addr=80000204.
//  2. inst_ready=0 for 5 cycles in RESP -> inst/inst_pc stable, imem_req=0; request resumes 1 cycle after ready.
//  3. Redirect to 80001000 while in WAIT, rvalid 3 cycles later
//     -> no inst_valid; next imem_addr=80001000; its response is delivered with inst_pc=80001000.
//  4. Redirect in the same cycle as imem_gnt for 80000208 -> that response is dropped; next fetch at redirect_addr.
//  5. TIMEOUT_CYC=4, no rvalid -> fetch_err pulse 4 cycles after WAIT entry, err_addr=req_pc;
//     imem_req stays 0 until redirect 80000180; late rvalid ignored.
//  6. Redirect to 80000402 -> fetch_err with err_addr=80000402, state ERR; assert rest_n=0 mid-WAIT
//     -> outputs 0 at once, fetch restarts at 80000200.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  // Default fetch address loaded by reset.
  localparam logic [31:0] FETCH_RESET_ADDR = 32'h8000_0200;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StResp = 3'd3,
    StErr  = 3'd4
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_timer.sv
// Bus-response watchdog: counts while enabled and pulses expire on the last
// allowed cycle. A limit of zero disables it.
module fetch_ctrl_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rest_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  // Count up while enabled; saturate at the limit so a suppressed expiry cannot wrap and refire.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != limit)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign expire = enable && (limit != '0) && (count_q == limit - WIDTH'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch address, keeps one imem request
// in flight, buffers the returned word for decode and applies redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = FETCH_RESET_ADDR,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rest_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_rt_addr,
  output logic        fetch_err,
  output logic [31:0] err_addr
);

  localparam int unsigned       TimerW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TimerW-1:0] TimerLimit = TimerW'(TIMEOUT_CYC);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;
  logic         kill_q;

  logic [31:0]  entry_addr;
  logic         bad_redirect;
  logic         granted;
  logic         in_wait;
  logic         timeout;

  // Address of the next request when (re)entering REQ: a redirect overrides fetch_pc.
  assign entry_addr   = redirect_valid ? redirect_addr : fetch_pc_q;
  assign bad_redirect = redirect_valid && !word_aligned(redirect_addr);
  assign granted      = (state_q == StReq) && imem_gnt;
  assign in_wait      = (state_q == StWait);

  fetch_ctrl_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk    (clk),
    .rest_n (rest_n),
    .clear  (!in_wait),
    .enable (in_wait),
    .limit  (TimerLimit),
    .expire (timeout)
  );

  // Fetch FSM with address registers, stale-response flag and all registered outputs.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_ADDR;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      inst_valid   <= 1'b0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_rt_addr <= '0;
      fetch_err    <= 1'b0;
      err_addr     <= '0;
    end else begin
      fetch_err <= 1'b0;
      if (redirect_valid) fetch_pc_q <= redirect_addr;
      if (granted) req_pc_q <= imem_addr;

      if (bad_redirect) begin
        // Any granted request is still on the bus; its response must be dropped later.
        state_q    <= StErr;
        imem_req   <= 1'b0;
        inst_valid <= 1'b0;
        fetch_err  <= 1'b1;
        err_addr   <= redirect_addr;
        kill_q     <= in_wait || granted;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StReq;
            imem_req  <= 1'b1;
            imem_addr <= entry_addr;
          end
          StReq: begin
            // The old address stays on the bus until granted; a redirect only marks it stale.
            if (redirect_valid) kill_q <= 1'b1;
            if (imem_gnt) begin
              state_q  <= StWait;
              imem_req <= 1'b0;
              // A stale request must not advance fetch_pc past the redirect target.
              if (!redirect_valid && !kill_q) fetch_pc_q <= imem_addr + 32'd4;
            end
          end
          StWait: begin
            if (imem_rvalid) begin
              if (redirect_valid || kill_q) begin
                kill_q    <= 1'b0;
                state_q   <= StReq;
                imem_req  <= 1'b1;
                imem_addr <= entry_addr;
              end else begin
                inst         <= imem_rdata;
                inst_pc      <= req_pc_q;
                inst_rt_addr <= req_pc_q + 32'd4;
                inst_valid   <= 1'b1;
                state_q      <= StResp;
              end
            end else if (redirect_valid) begin
              kill_q <= 1'b1;
            end else if (timeout) begin
              // The timed-out response is treated as lost, so nothing is left to drop.
              kill_q    <= 1'b0;
              fetch_err <= 1'b1;
              err_addr  <= req_pc_q;
              state_q   <= StErr;
            end
          end
          StResp: begin
            if (redirect_valid || inst_ready) begin
              inst_valid <= 1'b0;
              state_q    <= StReq;
              imem_req   <= 1'b1;
              imem_addr  <= entry_addr;
            end
          end
          StErr: begin
            if (redirect_valid) begin
              state_q   <= StReq;
              imem_req  <= 1'b1;
              imem_addr <= redirect_addr;
            end
          end
          default: begin
            state_q  <= StIdle;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
